bitwise_logic_accum: RTL
========================

# bitwise_logic_accum

Registered, op-selectable bitwise logic unit that generalises the single-operation XOR datapath into eight operations, adds valid/ready handshaking, and supports multi-beat accumulation (fold of a stream of operands into one result). It sits in the ALU logic path between the operand-select stage and the result writeback register. Backpressure from writeback is honoured without losing data.

## Interface
- WIDTH, 4, operand/result width in bits (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat present
- in_ready  output  1  unit can accept a beat this cycle
- op  input  3  operation code for this beat
- acc_mode  input  1  beat starts an accumulation packet (sampled only in IDLE)
- last  input  1  final beat of an accumulation packet
- a  input  WIDTH  left operand (ignored on non-first accumulation beats)
- b  input  WIDTH  right operand
- out_valid  output  1  result held
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- out_last  output  1  result closes an accumulation packet
- zero, parity  output  1 each  result flags (only with FLAGS_EN)

One clock; reset is asynchronous and active-low.

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT (~a, or ~acc), 7 ANDN (x & ~b). All bitwise, WIDTH bits, no carries.
- Accept = in_valid && in_ready; in_ready = !out_valid || out_ready.
- FSM IDLE/ACCUM:
  - IDLE, accepted, acc_mode=0: result ← a OP b, out_last ← 0, out_valid ← 1; stay IDLE.
  - IDLE, accepted, acc_mode=1, last=0: acc ← a OP b; go ACCUM; no output.
  - IDLE, accepted, acc_mode=1, last=1: result ← a OP b, out_last ← 1; stay IDLE.
  - ACCUM, accepted, last=0: acc ← acc OP b; no output.
  - ACCUM, accepted, last=1: result ← acc OP b, out_last ← 1, acc ← 0; go IDLE.
  - acc_mode ignored in ACCUM; op may change per beat.
- Output register: cleared valid when out_valid && out_ready and no new emitting beat; reload and drain in the same cycle allowed.
- Reset values: out_valid 0, result 0, out_last 0, zero 0, parity 0, acc 0, state IDLE. Reset mid-packet discards the packet.

## Timing
- Latency 1 cycle: emitting beat accepted at edge N → out_valid/result valid after edge N.
- Throughput 1 beat/cycle with out_ready=1; non-emitting ACCUM beats also gated by in_ready (no bypass).
- result/out_last/flags stable while out_valid && !out_ready.
- in_ready combinational from out_valid and out_ready only; no path from in_valid.

## Configuration
- BITWISE_LOGIC_FLAGS_EN defined: zero (result==0) and parity (^result) ports present, registered with result.
- Undefined: zero/parity ports and logic absent; all other behaviour identical.

## Structure
- Package bitwise_logic_pkg: op_e enum (3-bit, values above), state_e enum (IDLE, ACCUM).
- Sub-module bitwise_op_core: combinational (op, x, y) → z, WIDTH-parameterised; instantiated once, x muxed between a and acc.

## Test plan (WIDTH=4)
- Reset: hold rst_n=0 → out_valid 0, result 0000, in_ready 1; release → still idle.
- Single XOR: op=2, a=1100, b=1010, acc_mode=0 → next cycle result 0110, out_valid 1, out_last 0.
- Accumulation XOR: op=2, beats (a=0011,b=0101,acc_mode=1), (b=1111), (b=0001,last=1) → exactly one output, result 1000, out_last 1.
- Backpressure: out_valid=1, out_ready=0 → in_ready 0, result held 3 cycles; raise out_ready with in_valid=1 → drain and new beat accepted same cycle.
- Reset mid-packet: two ACCUM beats, pulse rst_n, then op=0, a=1111, b=0101 → result 0101, out_last 0, no stale acc.
- Flags (BITWISE_LOGIC_FLAGS_EN): op=5, a=1010, b=0101 → result 0000, zero 1, parity 0; op=2 same operands → 1111, zero 0, parity 0.

Source files
------------

// File: rtl/bitwise_logic_pkg.sv
// Shared types and helpers for the bitwise logic accumulator.
// Opcode and FSM state encodings, plus result-flag helper functions.
package bitwise_logic_pkg;

   localparam int MAX_WIDTH = 64;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOT  = 3'd6,
      OP_ANDN = 3'd7
   } op_e;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_e;

   // Zero-extension keeps both helpers valid for any WIDTH up to MAX_WIDTH.
   function automatic logic even_parity(input logic [MAX_WIDTH-1:0] v);
      return ^v;
   endfunction

   function automatic logic is_zero(input logic [MAX_WIDTH-1:0] v);
      return (v == {MAX_WIDTH{1'b0}});
   endfunction

endpackage

// File: rtl/bitwise_op_core.sv
// Combinational eight-operation bitwise core: z = x OP y.
module bitwise_op_core
   import bitwise_logic_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z
);

   // Opcode decode; NOT ignores y so it inverts either a or the accumulator.
   always_comb begin
      z = {WIDTH{1'b0}};
      case (op)
         OP_AND:  z = x & y;
         OP_OR:   z = x | y;
         OP_XOR:  z = x ^ y;
         OP_NAND: z = ~(x & y);
         OP_NOR:  z = ~(x | y);
         OP_XNOR: z = ~(x ^ y);
         OP_NOT:  z = ~x;
         OP_ANDN: z = x & ~y;
         default: z = {WIDTH{1'b0}};
      endcase
   end

endmodule

// File: rtl/bitwise_logic_accum.sv
// Registered bitwise logic unit with valid/ready handshake and multi-beat accumulation.
// Optional zero/parity result flags are built when BITWISE_LOGIC_FLAGS_EN is defined.
module bitwise_logic_accum
   import bitwise_logic_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             acc_mode,
   input  logic             last,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             out_last
`ifdef BITWISE_LOGIC_FLAGS_EN
  ,output logic             zero
  ,output logic             parity
`endif
);

   state_e           state_r;
   state_e           state_nxt_s;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] acc_nxt_s;
   logic [WIDTH-1:0] x_s;
   logic [WIDTH-1:0] z_s;
   logic             accept_s;
   logic             emit_s;
   logic             emit_last_s;
   logic [WIDTH-1:0] result_r;
   logic             out_valid_r;
   logic             out_last_r;

   // A held result only blocks input while downstream is stalling it.
   assign in_ready = !out_valid_r || out_ready;
   assign accept_s = in_valid && in_ready;

   // First packet beat uses a; later beats fold b into the running accumulator.
   assign x_s = (state_r == ACCUM) ? acc_r : a;

   bitwise_op_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op (op_e'(op)),
      .x  (x_s),
      .y  (b),
      .z  (z_s)
   );

   // Next-state, accumulator update and emit decision for the accepted beat.
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      emit_s      = 1'b0;
      emit_last_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (!acc_mode) begin
                  emit_s = 1'b1;
               end else if (last) begin
                  emit_s      = 1'b1;
                  emit_last_s = 1'b1;
               end else begin
                  acc_nxt_s   = z_s;
                  state_nxt_s = ACCUM;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCUM: begin
            if (accept_s) begin
               if (last) begin
                  emit_s      = 1'b1;
                  emit_last_s = 1'b1;
                  acc_nxt_s   = {WIDTH{1'b0}};
                  state_nxt_s = IDLE;
               end else begin
                  acc_nxt_s = z_s;
               end
            end else begin
               state_nxt_s = ACCUM;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            acc_nxt_s   = {WIDTH{1'b0}};
         end
      endcase
   end

   // FSM state and accumulator registers; reset discards any open packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         acc_r   <= {WIDTH{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         acc_r   <= acc_nxt_s;
      end
   end

   // Output holding register; a new result may replace one draining this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         result_r    <= {WIDTH{1'b0}};
         out_last_r  <= 1'b0;
      end else if (emit_s) begin
         out_valid_r <= 1'b1;
         result_r    <= z_s;
         out_last_r  <= emit_last_s;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign out_last  = out_last_r;

`ifdef BITWISE_LOGIC_FLAGS_EN
   logic zero_r;
   logic parity_r;

   // Flags load together with result so they stay aligned under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_r   <= 1'b0;
         parity_r <= 1'b0;
      end else if (emit_s) begin
         zero_r   <= is_zero(MAX_WIDTH'(z_s));
         parity_r <= even_parity(MAX_WIDTH'(z_s));
      end else begin
         zero_r   <= zero_r;
         parity_r <= parity_r;
      end
   end

   assign zero   = zero_r;
   assign parity = parity_r;
`endif

endmodule
